// File: rtl/bypass_network_nway.sv
// N-lane operand bypass for the execute stage: M, W, retired-write history or RF data, zero latency.
// No backpressure; ld_stall asks upstream to hold F/D/E on a load-use hazard.
module bypass_network_nway #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*REGW-1:0]   e_rs1,
  input  logic [LANES*REGW-1:0]   e_rs2,
  input  logic [LANES*XLEN-1:0]   e_rd1,
  input  logic [LANES*XLEN-1:0]   e_rd2,
  input  logic [LANES-1:0]        m_we,
  input  logic [LANES-1:0]        m_is_load,
  input  logic [LANES*REGW-1:0]   m_rd,
  input  logic [LANES*XLEN-1:0]   m_result,
  input  logic [LANES-1:0]        w_we,
  input  logic [LANES*REGW-1:0]   w_rd,
  input  logic [LANES*XLEN-1:0]   w_result,
  input  logic                    cnt_clr,
  output logic [LANES*XLEN-1:0]   e_src1,
  output logic [LANES*XLEN-1:0]   e_src2,
  output logic                    ld_stall,
  output logic [CNTW-1:0]         fwd_cnt
);

  localparam int HD   = (DEPTH > 0) ? DEPTH : 1;
  localparam int NUMW = $clog2(2 * LANES + 1);
  localparam int CW1  = CNTW + 1;

  logic [LANES-1:0] hist_we  [HD];
  logic [REGW-1:0]  hist_rd  [HD][LANES];
  logic [XLEN-1:0]  hist_res [HD][LANES];

  logic [NUMW-1:0]  fwd_num;
  logic [REGW-1:0]  src_reg;
  logic [XLEN-1:0]  src_val;
  logic             src_hit;
  logic             src_ld;
  logic [CW1-1:0]   cnt_sum;

  // Scan producers oldest to youngest so the last match is the youngest one.
  always_comb begin
    e_src1   = '0;
    e_src2   = '0;
    ld_stall = 1'b0;
    fwd_num  = '0;
    src_reg  = '0;
    src_val  = '0;
    src_hit  = 1'b0;
    src_ld   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < 2; s++) begin
        src_reg = (s == 0) ? e_rs1[l*REGW +: REGW] : e_rs2[l*REGW +: REGW];
        src_val = (s == 0) ? e_rd1[l*XLEN +: XLEN] : e_rd2[l*XLEN +: XLEN];
        src_hit = 1'b0;
        src_ld  = 1'b0;
        if (src_reg != '0) begin
          for (int k = DEPTH - 1; k >= 0; k--) begin
            for (int j = 0; j < LANES; j++) begin
              if (hist_we[k][j] && hist_rd[k][j] == src_reg) begin
                src_val = hist_res[k][j];
                src_hit = 1'b1;
              end
            end
          end
          for (int j = 0; j < LANES; j++) begin
            if (w_we[j] && w_rd[j*REGW +: REGW] == src_reg) begin
              src_val = w_result[j*XLEN +: XLEN];
              src_hit = 1'b1;
            end
          end
          for (int j = 0; j < LANES; j++) begin
            if (m_we[j] && m_rd[j*REGW +: REGW] == src_reg) begin
              src_val = m_result[j*XLEN +: XLEN];
              src_hit = 1'b1;
              src_ld  = m_is_load[j];
            end
          end
        end
        if (src_ld) begin
          ld_stall = 1'b1;
        end
        if (src_hit) begin
          fwd_num = fwd_num + NUMW'(1);
        end
        if (s == 0) begin
          e_src1[l*XLEN +: XLEN] = src_val;
        end else begin
          e_src2[l*XLEN +: XLEN] = src_val;
        end
      end
    end
  end

  if (DEPTH > 0) begin : g_hist
    // W always drains, so the history shifts even while the front end is stalled.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < HD; k++) begin
          hist_we[k] <= '0;
          for (int j = 0; j < LANES; j++) begin
            hist_rd[k][j]  <= '0;
            hist_res[k][j] <= '0;
          end
        end
      end else begin
        hist_we[0] <= w_we;
        for (int j = 0; j < LANES; j++) begin
          hist_rd[0][j]  <= w_rd[j*REGW +: REGW];
          hist_res[0][j] <= w_result[j*XLEN +: XLEN];
        end
        for (int k = 1; k < HD; k++) begin
          hist_we[k] <= hist_we[k-1];
          for (int j = 0; j < LANES; j++) begin
            hist_rd[k][j]  <= hist_rd[k-1][j];
            hist_res[k][j] <= hist_res[k-1][j];
          end
        end
      end
    end
  end else begin : g_no_hist
    always_comb begin
      for (int k = 0; k < HD; k++) begin
        hist_we[k] = '0;
        for (int j = 0; j < LANES; j++) begin
          hist_rd[k][j]  = '0;
          hist_res[k][j] = '0;
        end
      end
    end
  end

  assign cnt_sum = {1'b0, fwd_cnt} + CW1'(fwd_num);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt <= '0;
    end else if (cnt_clr) begin
      fwd_cnt <= '0;
    end else if (!ld_stall) begin
      fwd_cnt <= cnt_sum[CNTW] ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
    end
  end

endmodule

// File: tb/tb_bypass_network_nway.sv
// Directed bench for bypass_network_nway with the default 2-lane, DEPTH=2 configuration.
module tb_bypass_network_nway;

  localparam int L = 2;
  localparam int X = 32;
  localparam int R = 5;

  logic           clk;
  logic           reset;
  logic [L*R-1:0] e_rs1, e_rs2;
  logic [L*X-1:0] e_rd1, e_rd2;
  logic [L-1:0]   m_we, m_is_load;
  logic [L*R-1:0] m_rd;
  logic [L*X-1:0] m_result;
  logic [L-1:0]   w_we;
  logic [L*R-1:0] w_rd;
  logic [L*X-1:0] w_result;
  logic           cnt_clr;
  logic [L*X-1:0] e_src1, e_src2;
  logic           ld_stall;
  logic [15:0]    fwd_cnt;

  int vectors;
  int miscompares;

  bypass_network_nway dut (
    .clk(clk), .reset(reset),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd1(e_rd1), .e_rd2(e_rd2),
    .m_we(m_we), .m_is_load(m_is_load), .m_rd(m_rd), .m_result(m_result),
    .w_we(w_we), .w_rd(w_rd), .w_result(w_result),
    .cnt_clr(cnt_clr),
    .e_src1(e_src1), .e_src2(e_src2), .ld_stall(ld_stall), .fwd_cnt(fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    e_rs1 = '0; e_rs2 = '0; e_rd1 = '0; e_rd2 = '0;
    m_we = '0; m_is_load = '0; m_rd = '0; m_result = '0;
    w_we = '0; w_rd = '0; w_result = '0;
    cnt_clr = 1'b0;
  endtask

  task automatic set_m(input int lane, input logic ld, input logic [R-1:0] rd, input logic [X-1:0] res);
    m_we[lane] = 1'b1;
    m_is_load[lane] = ld;
    m_rd[lane*R +: R] = rd;
    m_result[lane*X +: X] = res;
  endtask

  task automatic set_w(input int lane, input logic we, input logic [R-1:0] rd, input logic [X-1:0] res);
    w_we[lane] = we;
    w_rd[lane*R +: R] = rd;
    w_result[lane*X +: X] = res;
  endtask

  task automatic flush();
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    e_rd1[0*X +: X] = 32'h1111;
    #2;
    vectors++;
    if (e_src1[0*X +: X] !== 32'h1111) begin
      miscompares++;
      $display("FAIL reset_src1 got %h want %h", e_src1[0*X +: X], 32'h1111);
    end
    vectors++;
    if (ld_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got %b want 0", ld_stall);
    end
    vectors++;
    if (fwd_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_cnt got %h want 0000", fwd_cnt);
    end
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (e_src1[0*X +: X] !== 32'h1111 || fwd_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL post_reset got src %h cnt %h want 00001111 0000", e_src1[0*X +: X], fwd_cnt);
    end
  endtask

  task automatic test_m_w_priority();
    flush();
    clear_count();
    e_rs1[1*R +: R] = 5'd5;
    e_rd1[1*X +: X] = 32'hDEAD;
    set_m(0, 1'b0, 5'd5, 32'hA);
    set_m(1, 1'b0, 5'd5, 32'hB);
    set_w(0, 1'b1, 5'd5, 32'hC);
    #1;
    vectors++;
    if (e_src1[1*X +: X] !== 32'hB) begin
      miscompares++;
      $display("FAIL m_lane1_wins got %h want 0000000b", e_src1[1*X +: X]);
    end
    m_we[1] = 1'b0;
    #1;
    vectors++;
    if (e_src1[1*X +: X] !== 32'hA) begin
      miscompares++;
      $display("FAIL m_over_w got %h want 0000000a", e_src1[1*X +: X]);
    end
    m_we[0] = 1'b0;
    set_w(1, 1'b1, 5'd5, 32'hD);
    #1;
    vectors++;
    if (e_src1[1*X +: X] !== 32'hD) begin
      miscompares++;
      $display("FAIL w_lane1_wins got %h want 0000000d", e_src1[1*X +: X]);
    end
    w_we[1] = 1'b0;
    #1;
    vectors++;
    if (e_src1[1*X +: X] !== 32'hC) begin
      miscompares++;
      $display("FAIL w_lane0 got %h want 0000000c", e_src1[1*X +: X]);
    end
    m_we = 2'b11;
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (fwd_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL m_fwd_count got %h want 0001", fwd_cnt);
    end
  endtask

  task automatic test_history();
    flush();
    set_w(1, 1'b1, 5'd7, 32'h77);
    tick();
    clear_inputs();
    e_rs2[0*R +: R] = 5'd7;
    e_rd2[0*X +: X] = 32'h5555;
    #1;
    vectors++;
    if (e_src2[0*X +: X] !== 32'h77) begin
      miscompares++;
      $display("FAIL hist0_hit got %h want 00000077", e_src2[0*X +: X]);
    end
    tick();
    vectors++;
    if (e_src2[0*X +: X] !== 32'h77) begin
      miscompares++;
      $display("FAIL hist1_hit got %h want 00000077", e_src2[0*X +: X]);
    end
    tick();
    vectors++;
    if (e_src2[0*X +: X] !== 32'h5555) begin
      miscompares++;
      $display("FAIL hist_expired got %h want 00005555", e_src2[0*X +: X]);
    end
    flush();
    set_w(1, 1'b0, 5'd7, 32'h99);
    tick();
    clear_inputs();
    e_rs2[0*R +: R] = 5'd7;
    e_rd2[0*X +: X] = 32'h5555;
    #1;
    vectors++;
    if (e_src2[0*X +: X] !== 32'h5555) begin
      miscompares++;
      $display("FAIL hist_bubble got %h want 00005555", e_src2[0*X +: X]);
    end
    flush();
    set_w(1, 1'b1, 5'd9, 32'h90);
    tick();
    set_w(1, 1'b0, 5'd0, 32'h0);
    set_w(0, 1'b1, 5'd9, 32'h91);
    tick();
    clear_inputs();
    e_rs1[0*R +: R] = 5'd9;
    #1;
    vectors++;
    if (e_src1[0*X +: X] !== 32'h91) begin
      miscompares++;
      $display("FAIL hist0_over_hist1 got %h want 00000091", e_src1[0*X +: X]);
    end
    flush();
    set_w(0, 1'b1, 5'd9, 32'hA0);
    set_w(1, 1'b1, 5'd9, 32'hA1);
    tick();
    clear_inputs();
    e_rs1[0*R +: R] = 5'd9;
    #1;
    vectors++;
    if (e_src1[0*X +: X] !== 32'hA1) begin
      miscompares++;
      $display("FAIL hist_lane1_wins got %h want 000000a1", e_src1[0*X +: X]);
    end
  endtask

  task automatic test_load_use();
    flush();
    clear_count();
    set_m(0, 1'b1, 5'd3, 32'h3000);
    set_w(0, 1'b1, 5'd8, 32'h88);
    e_rs1[1*R +: R] = 5'd3;
    e_rs2[0*R +: R] = 5'd8;
    #1;
    vectors++;
    if (ld_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_stall got %b want 1", ld_stall);
    end
    tick();
    vectors++;
    if (fwd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL stall_freezes_cnt got %h want 0000", fwd_cnt);
    end
    set_m(1, 1'b0, 5'd3, 32'h33);
    #1;
    vectors++;
    if (ld_stall !== 1'b0 || e_src1[1*X +: X] !== 32'h33) begin
      miscompares++;
      $display("FAIL younger_alu got stall %b src %h want 0 00000033", ld_stall, e_src1[1*X +: X]);
    end
    tick();
    vectors++;
    if (fwd_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL cnt_after_stall got %h want 0002", fwd_cnt);
    end
    set_m(0, 1'b0, 5'd3, 32'h3000);
    set_m(1, 1'b1, 5'd3, 32'h33);
    #1;
    vectors++;
    if (ld_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL younger_load got %b want 1", ld_stall);
    end
    e_rs1[1*R +: R] = 5'd4;
    e_rs2[0*R +: R] = 5'd0;
    #1;
    vectors++;
    if (ld_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_no_match got %b want 0", ld_stall);
    end
  endtask

  task automatic test_x0();
    flush();
    clear_count();
    set_m(0, 1'b1, 5'd0, 32'hFF);
    set_w(0, 1'b1, 5'd0, 32'hEE);
    e_rd1[0*X +: X] = 32'h1234;
    #1;
    vectors++;
    if (e_src1[0*X +: X] !== 32'h1234 || ld_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_no_bypass got src %h stall %b want 00001234 0", e_src1[0*X +: X], ld_stall);
    end
    tick();
    vectors++;
    if (fwd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL x0_no_count got %h want 0000", fwd_cnt);
    end
  endtask

  task automatic test_saturate();
    flush();
    set_m(0, 1'b0, 5'd1, 32'h1);
    set_m(1, 1'b0, 5'd2, 32'h2);
    e_rs1 = {5'd1, 5'd1};
    e_rs2 = {5'd2, 5'd2};
    clear_count();
    vectors++;
    if (fwd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL clr_priority got %h want 0000", fwd_cnt);
    end
    repeat (16383) tick();
    vectors++;
    if (fwd_cnt !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL cnt_fffc got %h want fffc", fwd_cnt);
    end
    e_rs2 = '0;
    tick();
    vectors++;
    if (fwd_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL cnt_fffe got %h want fffe", fwd_cnt);
    end
    e_rs2 = {5'd2, 5'd2};
    #1;
    vectors++;
    if (e_src2[1*X +: X] !== 32'h2 || e_src1[0*X +: X] !== 32'h1) begin
      miscompares++;
      $display("FAIL four_fwd_vals got %h %h want 00000002 00000001", e_src2[1*X +: X], e_src1[0*X +: X]);
    end
    tick();
    vectors++;
    if (fwd_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_saturate got %h want ffff", fwd_cnt);
    end
    tick();
    vectors++;
    if (fwd_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_no_wrap got %h want ffff", fwd_cnt);
    end
    clear_count();
    vectors++;
    if (fwd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL clr_while_fwd got %h want 0000", fwd_cnt);
    end
    tick();
    vectors++;
    if (fwd_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL cnt_after_clr got %h want 0004", fwd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    flush();
    set_w(1, 1'b1, 5'd7, 32'h77);
    tick();
    clear_inputs();
    e_rs2[0*R +: R] = 5'd7;
    e_rd2[0*X +: X] = 32'hABCD;
    set_m(0, 1'b1, 5'd4, 32'h4);
    e_rs1[0*R +: R] = 5'd4;
    #1;
    vectors++;
    if (e_src2[0*X +: X] !== 32'h77 || ld_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset got src %h stall %b want 00000077 1", e_src2[0*X +: X], ld_stall);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (fwd_cnt !== 16'd0 || e_src2[0*X +: X] !== 32'hABCD) begin
      miscompares++;
      $display("FAIL async_reset got cnt %h src %h want 0000 0000abcd", fwd_cnt, e_src2[0*X +: X]);
    end
    m_we = '0;
    #1;
    vectors++;
    if (ld_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall_clear got %b want 0", ld_stall);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (e_src2[0*X +: X] !== 32'hABCD || fwd_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL hist_cleared got src %h cnt %h want 0000abcd 0000", e_src2[0*X +: X], fwd_cnt);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_m_w_priority();
    test_history();
    test_load_use();
    test_x0();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
